i2s_tx: RTL and testbench
=========================

# i2s_tx

Stereo I2S transmitter that turns parallel left/right PCM samples into the MCLK/LRCK/SCK/SDOUT stream for the board's I2S DAC. It sits directly upstream of the DAC pins in `top`. Sample sources (oscillators and mixers) feed it through a valid/ready handshake. All clocks are derived from the 100 MHz system clock, with fixed ratios MCLK/LRCK = 256 and SCK/LRCK = 64.

## Interface
- `DATA_W`, 24: sample width, 1..31, MSB-first, two's complement.
- `MCLK_LOG2`, 3: log2 of system clocks per MCLK period, ≥1. The default of 3 gives 12.5 MHz MCLK and a 48.83 kHz frame rate.

- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `s_left` in DATA_W: left sample.
- `s_right` in DATA_W: right sample.
- `s_valid` in 1: the sample pair is valid.
- `s_ready` out 1: the block can accept a pair. A transfer happens on `s_valid && s_ready` at a rising edge of `clk`.
- `mclk` out 1: DAC master clock.
- `lrck` out 1: word select. 0 means the left channel, 1 means the right channel.
- `sck` out 1: serial bit clock.
- `sdout` out 1: serial data.
- `underrun` out 1: one-clk pulse at a frame start when no sample pair was waiting.

## Operation
- **Counter.** A free-running counter `cnt` of width C = MCLK_LOG2+8 increments every clk and wraps from 2^C−1 to 0.
- **Clock outputs.** Let L = MCLK_LOG2. The clock outputs are counter bits, so they are glitch-free register outputs:
  - `mclk` = `cnt[L−1]`
  - `sck` = `cnt[L+1]`
  - `lrck` = `cnt[L+7]`
- **Slots.** Each half-frame holds 32 SCK slots. The slot index is `cnt[L+6:L+2]`.
- **Holding register.** A single-entry holding register stores one L/R pair, with a full flag `hold_full`.
  - `s_ready` = `!hold_full`. `s_ready` is forced to 0 while `rst` is low.
  - An accepted pair sets `hold_full`.
- **Frame start.** Frame start is the edge where `cnt` wraps to 0.
  - If `hold_full` is set: copy the holding pair into `frame_l`/`frame_r` and clear `hold_full`.
  - If `hold_full` is clear: load zeros into `frame_l`/`frame_r` and pulse `underrun` for one clk.
- **Accept on the frame-start edge.** If the holding register was empty, an accept on the frame-start edge goes into the holding register, not the frame registers. That frame still underruns, and the accepted pair plays in the following frame.
- **Slot contents.** This is the I2S format, with data one SCK after the LRCK edge.
  - Slot 0 carries 0.
  - Slots 1..DATA_W carry sample bits DATA_W−1 down to 0.
  - The remaining slots carry 0.
  - The left half uses `frame_l`; the right half uses `frame_r`.
- **`sdout` updates.** `sdout` is registered. It updates only on edges where `cnt[L+1:0]` is all ones, which is the edge where `sck` falls. The new value is the bit belonging to the slot and channel of `cnt+1`.
- **Reset.** While `rst` is low:
  - `cnt`, `mclk`, `sck`, `lrck`, `sdout`, `underrun`, `hold_full`, `frame_l` and `frame_r` are all 0.
  - The first frame after reset plays zeros and raises no `underrun`.
- **Reset mid-frame.** The frame is abandoned and all outputs go to 0 immediately. Any held pair is discarded.

## Timing
- With default parameters, counting from the first edge after `rst` is released:
  - `mclk` first rises at edge 4, with a period of 8 clk.
  - `sck` first rises at edge 16, with a period of 32 clk.
  - `lrck` first rises at edge 1024, with a period of 2048 clk.
- `sdout` changes on the same clk edge as the `sck` falling edge. It is stable for 16 clk before each `sck` rising edge.
- **Latency.** A pair accepted at any edge before frame start N is loaded at frame start N. Its left MSB appears on `sdout` 32 clk after frame start N, and its right MSB 1056 clk after frame start N.
- **Throughput.** One pair per frame (2^C clk). `s_ready` stays low from an accept until the next frame start.

## Structure
- **Shared package `i2s_pkg`.** Holds:
  - the slot count (32 per channel)
  - the MCLK/LRCK and SCK/LRCK ratios
  - the counter-width function of MCLK_LOG2
  - a packed stereo sample typedef (`left`, `right`)
- **Sub-module `i2s_clkgen`.** Contains the counter and the clock-bit taps, and exports `frame_start`, `sck_fall_next`, `slot` and `chan` strobes. `i2s_tx` holds the handshake, the frame registers and the `sdout` mux.

## Test plan
- **Reset check.** Hold `rst` low for 5 clk, then release.
  - All outputs are 0 during reset.
  - The `mclk`, `sck` and `lrck` edges land at clk 4, 16 and 1024 with periods 8, 32 and 2048.
  - `sdout` stays 0 for the first frame, and `underrun` is not asserted.
- **Single pair.** Send left = 0x800001, right = 0x7FFFFE before the first wrap.
  - Sampling `sdout` on `sck` rises gives left slots 1..24 = 1000…0001 and right slots 1..24 = 0111…1110.
  - Slot 0 and slots 25..31 are 0.
- **Underrun.** Hold `s_valid` low across a wrap.
  - `underrun` pulses high for exactly 1 clk at the wrap edge.
  - The whole frame is 0 on `sdout`.
- **Back-pressure.** Hold `s_valid` high continuously with incrementing values.
  - Exactly one accept happens per 2048 clk.
  - `s_ready` drops the cycle after each accept and returns at frame start.
  - The frames play in order with no gaps.
- **Accept on the wrap edge.** With the holding register empty, accept 0x123456/0x654321 exactly on the wrap edge.
  - That frame underruns.
  - The pair plays in the next frame.
- **Mid-frame reset.** Assert `rst` at clk 1500 of a frame carrying 0xFFFFFF.
  - All outputs drop to 0 asynchronously.
  - After release, the timing restarts as in the reset-check scenario and the old sample is not replayed.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants, stereo sample type and helpers for the I2S transmitter.
package i2s_pkg;

    localparam int SLOTS_PER_CHAN = 32;
    localparam int MCLK_PER_LRCK  = 256;
    localparam int SCK_PER_LRCK   = 64;
    localparam int SLOT_W         = $clog2(SLOTS_PER_CHAN);
    localparam int WORD_W         = SLOTS_PER_CHAN;

    // One channel word holds every slot of a half-frame, slot 0 in the MSB.
    typedef struct packed {
        logic [WORD_W-1:0] left;
        logic [WORD_W-1:0] right;
    } stereo_t;

    function automatic int cnt_width(input int mclk_log2);
        return mclk_log2 + $clog2(MCLK_PER_LRCK);
    endfunction

    function automatic int sck_bit(input int mclk_log2);
        return mclk_log2 - 1 + $clog2(MCLK_PER_LRCK / SCK_PER_LRCK);
    endfunction

    // Place a sample so its MSB lands in slot 1; slot 0 and trailing slots stay 0.
    function automatic logic [WORD_W-1:0] slot_align(input logic [WORD_W-1:0] sample,
                                                     input int data_w);
        return sample << (WORD_W - 1 - data_w);
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-pair valid/ready stream feeding the I2S transmitter.
interface i2s_tx_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_left, output s_right, output s_valid, input s_ready);
    modport slave  (input s_left, input s_right, input s_valid, output s_ready);
endinterface

// File: rtl/i2s_clkgen.sv
// Free-running frame counter; MCLK/SCK/LRCK are plain counter bits.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int MCLK_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mclk,
    output logic              sck,
    output logic              lrck,
    output logic              frame_start,
    output logic              sck_fall_next,
    output logic [SLOT_W-1:0] slot,
    output logic              chan
);

    localparam int CW      = cnt_width(MCLK_LOG2);
    localparam int SCK_BIT = sck_bit(MCLK_LOG2);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    assign cnt_next = cnt_reg + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign mclk          = cnt_reg[MCLK_LOG2-1];
    assign sck           = cnt_reg[SCK_BIT];
    assign lrck          = cnt_reg[CW-1];
    assign frame_start   = &cnt_reg;
    assign sck_fall_next = &cnt_reg[SCK_BIT:0];

    // Slot/channel refer to the counter value after the coming edge.
    assign slot = cnt_next[CW-2 -: SLOT_W];
    assign chan = cnt_next[CW-1];

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: one-deep holding register, per-frame sample latch, SDOUT mux.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int MCLK_LOG2 = 3
) (
    input  logic     clk,
    input  logic     rst,
    i2s_tx_if.slave  sbus,
    output logic     mclk,
    output logic     lrck,
    output logic     sck,
    output logic     sdout,
    output logic     underrun
);

    logic              frame_start;
    logic              sck_fall_next;
    logic [SLOT_W-1:0] slot;
    logic              chan;

    stereo_t           hold_reg;
    stereo_t           frame_reg;
    logic              hold_full_reg;
    logic              sdout_reg;
    logic              underrun_reg;
    logic              accept;
    logic [WORD_W-1:0] word;
    logic [SLOT_W-1:0] bit_sel;

    i2s_clkgen #(
        .MCLK_LOG2 (MCLK_LOG2)
    ) u_clkgen (
        .clk           (clk),
        .rst           (rst),
        .mclk          (mclk),
        .sck           (sck),
        .lrck          (lrck),
        .frame_start   (frame_start),
        .sck_fall_next (sck_fall_next),
        .slot          (slot),
        .chan          (chan)
    );

    assign sbus.s_ready = rst & ~hold_full_reg;
    assign accept       = sbus.s_valid & sbus.s_ready;

    assign word    = chan ? frame_reg.right : frame_reg.left;
    assign bit_sel = SLOT_W'(WORD_W - 1) - slot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_reg      <= '0;
            frame_reg     <= '0;
            hold_full_reg <= 1'b0;
            sdout_reg     <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            underrun_reg <= frame_start & ~hold_full_reg;
            // An accept on the wrap edge lands in the holding register for the next frame.
            if (frame_start) begin
                frame_reg     <= hold_full_reg ? hold_reg : '0;
                hold_full_reg <= accept;
            end else if (accept) begin
                hold_full_reg <= 1'b1;
            end
            if (accept) begin
                hold_reg <= '{left:  slot_align(WORD_W'(sbus.s_left), DATA_W),
                              right: slot_align(WORD_W'(sbus.s_right), DATA_W)};
            end
            if (sck_fall_next) begin
                sdout_reg <= word[bit_sel];
            end
        end
    end

    assign sdout    = sdout_reg;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: clock timing, slot contents, underrun, back-pressure, resets.
module tb_i2s_tx;

    logic clk;
    logic rst;
    logic mclk, lrck, sck, sdout, underrun;

    int   checks   = 0;
    int   failures = 0;
    int   edge_no  = 0;
    int   fpos     = 0;
    bit   pending  = 0;
    bit   accepted = 0;
    bit   feed_keep = 0;
    int   feed_n   = 0;
    int   last_acc_pos = -1;

    i2s_tx_if #(.DATA_W(24)) bus ();

    i2s_tx #(
        .DATA_W    (24),
        .MCLK_LOG2 (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sbus     (bus),
        .mclk     (mclk),
        .lrck     (lrck),
        .sck      (sck),
        .sdout    (sdout),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clk; tracks frame position and the expected s_ready state.
    task automatic tick();
        logic       take;
        logic [2:0] exp_clk;
        take = bus.s_valid && bus.s_ready;
        @(posedge clk);
        #1;
        edge_no++;
        fpos     = edge_no % 2048;
        accepted = take;
        if (fpos == 0) pending = 0;
        if (take) pending = 1;
        exp_clk = {(fpos % 8) >= 4, (fpos % 32) >= 16, fpos >= 1024};
        checks++;
        if ({mclk, sck, lrck} !== exp_clk) begin
            failures++;
            if (failures <= 50)
                $display("FAIL clocks edge=%0d got=%b want=%b", edge_no, {mclk, sck, lrck}, exp_clk);
        end
        checks++;
        if (bus.s_ready !== !pending) begin
            failures++;
            if (failures <= 50)
                $display("FAIL s_ready edge=%0d got=%b want=%b", edge_no, bus.s_ready, !pending);
        end
    endtask

    task automatic run_idle(input int stop);
        while (fpos != stop) begin
            tick();
            checks++;
            if ({sdout, underrun} !== 2'b00) begin
                failures++;
                if (failures <= 50)
                    $display("FAIL idle_zero edge=%0d got sdout=%b underrun=%b want 0", edge_no, sdout, underrun);
            end
        end
    endtask

    // Play one full frame starting from the wrap edge, checking every SCK-rise sample.
    task automatic play_frame(input logic [23:0] el, input logic [23:0] er,
                              input bit eur, input string tag);
        int          n_acc;
        int          slot;
        logic [23:0] word;
        logic        expb;
        logic        exp_ur;
        n_acc = 0;
        for (int i = 0; i < 2048; i++) begin
            tick();
            if (accepted) begin
                n_acc++;
                last_acc_pos = fpos;
                $display("accept edge=%0d pos=%0d left=%06h right=%06h",
                         edge_no, fpos, bus.s_left, bus.s_right);
                if (feed_keep) begin
                    feed_n++;
                    bus.s_left  = 24'h5A0000 + 24'(feed_n);
                    bus.s_right = 24'hA50000 + 24'(feed_n);
                end else begin
                    bus.s_valid = 1'b0;
                end
            end
            exp_ur = (fpos == 0) && eur;
            checks++;
            if (underrun !== exp_ur) begin
                failures++;
                if (failures <= 50)
                    $display("FAIL %s underrun pos=%0d got=%b want=%b", tag, fpos, underrun, exp_ur);
            end
            if (fpos % 32 == 16) begin
                slot = (fpos / 32) % 32;
                word = (fpos >= 1024) ? er : el;
                expb = (slot >= 1 && slot <= 24) ? word[24 - slot] : 1'b0;
                checks++;
                if (sdout !== expb) begin
                    failures++;
                    if (failures <= 50)
                        $display("FAIL %s sdout ch=%0d slot=%0d got=%b want=%b",
                                 tag, fpos >= 1024, slot, sdout, expb);
                end
            end
        end
        checks++;
        if (n_acc > 1) begin
            failures++;
            $display("FAIL %s accepts_per_frame got=%0d want<=1", tag, n_acc);
        end
        $display("frame %s left=%06h right=%06h underrun=%0d", tag, el, er, eur);
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_left  = '0;
        bus.s_right = '0;
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({mclk, sck, lrck, sdout, underrun, bus.s_ready} !== 6'b0) begin
                failures++;
                $display("FAIL reset_outputs got=%b want=000000",
                         {mclk, sck, lrck, sdout, underrun, bus.s_ready});
            end
        end
        @(posedge clk);
        #1;
        rst     = 1'b1;
        edge_no = 0;
        fpos    = 0;
        pending = 0;
        run_idle(1100);
        $display("reset timing checked to edge=%0d", edge_no);
    endtask

    task automatic test_single_pair();
        bit got;
        got         = 0;
        bus.s_left  = 24'h800001;
        bus.s_right = 24'h7FFFFE;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (accepted) got = 1;
        end
        bus.s_valid = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL single_accept got=none want=accept within 8 clk");
        end
        $display("accept edge=%0d left=800001 right=7ffffe", edge_no);
        run_idle(2047);
        play_frame(24'h800001, 24'h7FFFFE, 1'b0, "single_pair");
    endtask

    task automatic test_underrun();
        bus.s_valid = 1'b0;
        play_frame(24'h0, 24'h0, 1'b1, "underrun");
    endtask

    task automatic test_wrap_accept();
        bus.s_left   = 24'h123456;
        bus.s_right  = 24'h654321;
        bus.s_valid  = 1'b1;
        feed_keep    = 0;
        last_acc_pos = -1;
        play_frame(24'h0, 24'h0, 1'b1, "wrap_accept_ur");
        checks++;
        if (last_acc_pos !== 0) begin
            failures++;
            $display("FAIL wrap_accept_pos got=%0d want=0", last_acc_pos);
        end
        play_frame(24'h123456, 24'h654321, 1'b0, "wrap_accept_play");
    endtask

    task automatic test_back_to_back();
        feed_n       = 1;
        bus.s_left   = 24'h5A0001;
        bus.s_right  = 24'hA50001;
        bus.s_valid  = 1'b1;
        feed_keep    = 1;
        last_acc_pos = -1;
        play_frame(24'h0, 24'h0, 1'b1, "b2b_fill");
        checks++;
        if (last_acc_pos !== 0) begin
            failures++;
            $display("FAIL b2b_fill_pos got=%0d want=0", last_acc_pos);
        end
        for (int n = 1; n <= 4; n++) begin
            if (n == 4) begin
                bus.s_left  = 24'hFFFFFF;
                bus.s_right = 24'hFFFFFF;
                feed_keep   = 0;
            end
            last_acc_pos = -1;
            play_frame(24'h5A0000 + 24'(n), 24'hA50000 + 24'(n), 1'b0, "b2b");
            checks++;
            if (last_acc_pos !== 1) begin
                failures++;
                $display("FAIL b2b_accept_pos frame=%0d got=%0d want=1", n, last_acc_pos);
            end
        end
    endtask

    task automatic test_mid_reset();
        int slot;
        bus.s_left  = 24'h0F0F0F;
        bus.s_right = 24'h0F0F0F;
        bus.s_valid = 1'b1;
        while (fpos != 1500) begin
            tick();
            if (accepted) begin
                bus.s_valid = 1'b0;
                $display("accept edge=%0d pos=%0d left=0f0f0f right=0f0f0f", edge_no, fpos);
            end
            checks++;
            if (underrun !== 1'b0) begin
                failures++;
                $display("FAIL mid_underrun pos=%0d got=%b want=0", fpos, underrun);
            end
            if (fpos % 32 == 16) begin
                slot = (fpos / 32) % 32;
                checks++;
                if (sdout !== (slot >= 1 && slot <= 24)) begin
                    failures++;
                    $display("FAIL mid_sdout slot=%0d got=%b want=%b", slot, sdout, slot >= 1 && slot <= 24);
                end
            end
        end
        checks++;
        if ({sdout, bus.s_ready} !== 2'b10) begin
            failures++;
            $display("FAIL pre_reset got sdout,s_ready=%b want=10", {sdout, bus.s_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({mclk, sck, lrck, sdout, underrun, bus.s_ready} !== 6'b0) begin
            failures++;
            $display("FAIL async_reset got=%b want=000000", {mclk, sck, lrck, sdout, underrun, bus.s_ready});
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({mclk, sck, lrck, sdout, underrun, bus.s_ready} !== 6'b0) begin
                failures++;
                $display("FAIL held_reset got=%b want=000000", {mclk, sck, lrck, sdout, underrun, bus.s_ready});
            end
        end
        @(posedge clk);
        #1;
        rst     = 1'b1;
        edge_no = 0;
        fpos    = 0;
        pending = 0;
        $display("reset released mid-frame, restarting");
        run_idle(2047);
        play_frame(24'h0, 24'h0, 1'b1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_underrun();
        test_wrap_accept();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
